// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote, optional parity,
// and a first-word fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_rx,
    input  logic                          i_rd_en,
    output logic [DATA_BITS-1:0]          o_rd_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overrun,
    input  logic                          i_clr_err
);
    localparam int unsigned DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic        PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_t;

    state_t                r_state;
    logic                  r_sync1, r_sync2;
    logic [DIV_W-1:0]      r_div;
    logic [3:0]            r_smp;
    logic                  r_s7, r_s8;
    logic [2:0]            r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par, r_par_bad;
    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic [DATA_BITS-1:0]  r_last;
    logic                  r_frame_err, r_parity_err, r_overrun;

    logic w_rx, w_tick, w_maj, w_stop_mid;
    logic w_push, w_pop, w_wr, w_frame_set, w_parity_set, w_ovr_set;

    assign w_rx       = r_sync2;
    assign w_tick     = (r_div == DIV_W'(DIV - 1));
    assign w_maj      = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
    assign w_stop_mid = (r_state == StStop) && w_tick && (r_smp == 4'd9);

    assign w_push       = w_stop_mid && w_maj && !r_par_bad;
    assign w_frame_set  = w_stop_mid && !w_maj;
    assign w_parity_set = w_stop_mid && w_maj && r_par_bad;
    assign w_pop        = i_rd_en && !o_empty;
    assign w_wr         = w_push && (!o_full || w_pop);
    assign w_ovr_set    = w_push && o_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running divider, realigned to the falling edge of each start bit.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_div <= '0;
        end else if ((r_state == StIdle && !w_rx) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= StIdle;
            r_smp     <= 4'd0;
            r_s7      <= 1'b1;
            r_s8      <= 1'b1;
            r_bit     <= 3'd0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_rx) begin
                        r_state   <= StStart;
                        r_smp     <= 4'd0;
                        r_bit     <= 3'd0;
                        r_par     <= 1'b0;
                        r_par_bad <= 1'b0;
                    end
                end
                StWaitHigh: begin
                    if (w_rx) r_state <= StIdle;
                end
                default: begin
                    if (w_tick) begin
                        r_smp <= r_smp + 4'd1;
                        if (r_smp == 4'd7) r_s7 <= w_rx;
                        if (r_smp == 4'd8) r_s8 <= w_rx;
                        if (r_smp == 4'd9) begin
                            case (r_state)
                                StStart: r_state <= w_maj ? StIdle : StData;
                                StData: begin
                                    r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                                    r_par   <= r_par ^ w_maj;
                                    r_bit   <= r_bit + 3'd1;
                                    if (r_bit == 3'(DATA_BITS - 1)) begin
                                        r_state <= (PARITY != 0) ? StParity : StStop;
                                    end
                                end
                                StParity: begin
                                    r_par_bad <= ((r_par ^ w_maj) != PAR_ODD);
                                    r_state   <= StStop;
                                end
                                StStop:  r_state <= w_maj ? StIdle : StWaitHigh;
                                default: r_state <= StIdle;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_last <= r_mem[r_rptr];
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    // Error sets take priority over a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_set  | (r_frame_err  & ~i_clr_err);
            r_parity_err <= w_parity_set | (r_parity_err & ~i_clr_err);
            r_overrun    <= w_ovr_set    | (r_overrun    & ~i_clr_err);
        end
    end

    // When empty, keep showing the most recently popped word.
    assign o_rd_data    = o_empty ? r_last : r_mem[r_rptr];
    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == CW'(FIFO_DEPTH));
    assign o_count      = r_count;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8N1 9600-baud receiver. Adds 16x oversampling with 3-sample majority vote, configurable data width and parity, and a receive FIFO with sticky error flags. Sits between the HC-06 RX pin and command/LED logic, so consumers drain bytes at their own pace instead of catching a one-cycle pulse.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; fixed at 16, other values unsupported
DATA_BITS, 8, data bits per frame, legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 16, FIFO entries; must be a power of 2, minimum 2

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop request for the FIFO head
rd_data  out  DATA_BITS  FIFO head word, first-word fall-through
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  number of words stored
frame_err  out  1  sticky; stop bit sampled low
parity_err  out  1  sticky; parity mismatch
overrun  out  1  sticky; frame completed while FIFO full with no pop
clr_err  in  1  clears all three sticky flags

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE, FIFO emptied, count=0, empty=1, full=0, rd_data=0, all error flags 0, tick divider 0. Applies mid-frame; the partial frame is discarded.
- rx passes through a 2-FF synchronizer, initialised to 1. All following references to rx mean the synchronized value.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*16), integer truncation. Produces a 1-clk tick every DIV clocks, free-running. The tick counter restarts at 0 when leaving IDLE.
- Sample counter runs 0..15 per bit. The bit value is the majority of samples 7, 8 and 9, latched at sample 9.
- States:
  - IDLE: wait for rx=0, then go to START.
  - START: at sample 9, majority 0 goes to DATA; majority 1 is a glitch and returns to IDLE with no flag.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit go to PARITY if PARITY≠0, else STOP.
  - PARITY: compute XOR of the data bits plus the parity bit. Even mode requires 0, odd mode requires 1. A mismatch is remembered for this frame.
  - STOP: at sample 9 of the stop bit, resolve the frame (rules below).
- Stop-bit resolution:
  - Majority 0: set frame_err, discard the word, go to WAIT_HIGH.
  - Else, parity mismatch: set parity_err, discard the word, go to IDLE.
  - Else: push the word and go to IDLE. Second stop bits are not checked.
- WAIT_HIGH: stay until rx=1, then go to IDLE. A break condition therefore yields exactly one frame_err.
- Push timing: the word becomes visible on rd_data and empty deasserts 1 clk after the sample-9 tick. Latency from the stop-bit centre is therefore 1 clk.
- FIFO:
  - Pointers are circular and wrap modulo FIFO_DEPTH.
  - rd_en with empty=1 is ignored.
  - Push and pop in the same cycle both succeed and count is unchanged. This holds when full.
  - Push when full with no rd_en: word dropped, overrun set, contents untouched.
- rd_data always shows the head word. Its value is don't-care when empty, but it must hold its last value.
- clr_err clears all flags. If an error sets in the same cycle as clr_err, set wins.

Test Plan:
1. Bench CLK_FREQ=16_000_000, BAUD_RATE=1_000_000 (DIV=1), 8N1. Send 0x51 ('Q') → empty falls 1 clk after stop-bit sample 9; rd_data=0x51; count=1; pulse rd_en → empty=1, count=0.
2. PARITY=2, DATA_BITS=7. Send 0x41 with parity bit 0 → pushed as 0x41. Send 0x43 with parity bit 0 → parity_err=1, count unchanged. Pulse clr_err → parity_err=0.
3. FIFO_DEPTH=4. Send 0x30..0x34 with no reads → count=4, full=1, overrun=1, and reads return 0x30, 0x31, 0x32, 0x33. Repeat with rd_en asserted on the 5th push cycle → count stays 4, overrun=0.
4. Hold rx low for 3 bit times → exactly one frame_err, no push. Release rx, then send 0x39 → received correctly.
5. Glitch rx low for 4 clks at DIV=1 (shorter than the half-bit point) → returns to IDLE, no push, no flags. Flip one of samples 7/8/9 within a data bit → majority gives the correct byte.
6. Assert reset_n low for 1 clk in mid-DATA of the 2nd frame, with 1 word stored → count=0, empty=1, flags 0. The next clean frame 0xA5 is received correctly.
